// File: rtl/game_event_uart_tx_if.sv
// Game-loop side of the event UART transmitter: event pulses,
// live scores in, serial line and busy status out.
interface game_event_uart_tx_if;
    logic       evStart;
    logic       evP1Score;
    logic       evP2Score;
    logic [3:0] p1Score;
    logic [3:0] p2Score;
    logic       tx;
    logic       busy;

    modport master (
        output evStart,
        output evP1Score,
        output evP2Score,
        output p1Score,
        output p2Score,
        input  tx,
        input  busy
    );

    modport slave (
        input  evStart,
        input  evP1Score,
        input  evP2Score,
        input  p1Score,
        input  p2Score,
        output tx,
        output busy
    );
endinterface

// File: rtl/game_event_uart_tx.sv
// Sends a 4-byte ASCII message (tag, p1 digit, p2 digit, CR) per game
// event over an 8N1 UART line; events queue as sticky pending flags.
module game_event_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic                 Clock,
    input  logic                 reset,
    game_event_uart_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0] K_S = 2'd0;
    localparam logic [1:0] K_1 = 2'd1;
    localparam logic [1:0] K_2 = 2'd2;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bitIdx, bitIdx_n;
    logic [1:0]       byteIdx, byteIdx_n;
    logic [7:0]       shreg, shreg_n;
    logic             txq, tx_n;
    logic             pendS, pendS_n;
    logic             pend1, pend1_n;
    logic             pend2, pend2_n;
    logic [1:0]       kind, kind_n;
    logic [3:0]       snap1, snap1_n;
    logic [3:0]       snap2, snap2_n;
    logic [7:0]       tagByte;
    logic [7:0]       curByte;
    logic             wrap;

    function automatic logic [7:0] digit(input logic [3:0] v);
        return (v <= 4'd9) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
    endfunction

    assign wrap     = (cnt == CNT_MAX);
    assign bus.tx   = txq;
    assign bus.busy = (state != IDLE);

    always_comb begin
        tagByte = 8'h32;
        if (kind == K_S)
            tagByte = 8'h53;
        else if (kind == K_1)
            tagByte = 8'h31;
    end

    always_comb begin
        curByte = 8'h0D;
        unique case (byteIdx)
            2'd0:    curByte = tagByte;
            2'd1:    curByte = digit(snap1);
            2'd2:    curByte = digit(snap2);
            default: curByte = 8'h0D;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = wrap ? '0 : cnt + CNT_W'(1);
        bitIdx_n  = bitIdx;
        byteIdx_n = byteIdx;
        shreg_n   = shreg;
        tx_n      = txq;
        kind_n    = kind;
        snap1_n   = snap1;
        snap2_n   = snap2;
        // A pulse landing on the acceptance edge re-arms its flag.
        pendS_n   = pendS | bus.evStart;
        pend1_n   = pend1 | bus.evP1Score;
        pend2_n   = pend2 | bus.evP2Score;

        unique case (state)
            IDLE: begin
                tx_n  = 1'b1;
                cnt_n = '0;
                if (pendS | pend1 | pend2) begin
                    state_n   = LOAD;
                    byteIdx_n = 2'd0;
                    snap1_n   = bus.p1Score;
                    snap2_n   = bus.p2Score;
                    if (pendS) begin
                        kind_n  = K_S;
                        pendS_n = bus.evStart;
                    end else if (pend1) begin
                        kind_n  = K_1;
                        pend1_n = bus.evP1Score;
                    end else begin
                        kind_n  = K_2;
                        pend2_n = bus.evP2Score;
                    end
                end
            end
            LOAD: begin
                shreg_n = curByte;
                cnt_n   = '0;
                tx_n    = 1'b0;
                state_n = START;
            end
            START: begin
                if (wrap) begin
                    state_n  = DATA;
                    bitIdx_n = 3'd0;
                    tx_n     = shreg[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bitIdx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bitIdx_n = bitIdx + 3'd1;
                        shreg_n  = {1'b0, shreg[7:1]};
                        tx_n     = shreg[1];
                    end
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (wrap) begin
                    if (byteIdx == 2'd3) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = LOAD;
                        byteIdx_n = byteIdx + 2'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bitIdx  <= '0;
            byteIdx <= '0;
            shreg   <= '0;
            txq     <= 1'b1;
            pendS   <= 1'b0;
            pend1   <= 1'b0;
            pend2   <= 1'b0;
            kind    <= K_S;
            snap1   <= '0;
            snap2   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bitIdx  <= bitIdx_n;
            byteIdx <= byteIdx_n;
            shreg   <= shreg_n;
            txq     <= tx_n;
            pendS   <= pendS_n;
            pend1   <= pend1_n;
            pend2   <= pend2_n;
            kind    <= kind_n;
            snap1   <= snap1_n;
            snap2   <= snap2_n;
        end
    end

endmodule

// File: tb/tb_game_event_uart_tx.sv
// Directed bench for game_event_uart_tx: per-cycle tx capture while busy,
// decoded at mid-bit positions and compared with hand-computed bytes.
module tb_game_event_uart_tx;

    localparam int CPB = 4;
    localparam int MSG = 4 * (10 * CPB + 1);

    typedef struct {
        logic       s;
        logic       a;
        logic       b;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } vec_t;

    logic Clock = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;
    bit   smp[$];

    game_event_uart_tx_if bus();

    game_event_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(3)
    ) dut (
        .Clock(Clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 Clock = ~Clock;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic capture(output int n);
        smp.delete();
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clock);
            if (!bus.busy) break;
            smp.push_back(bus.tx);
            n++;
        end
    endtask

    function automatic logic [7:0] rxbyte(input int j);
        logic [7:0] r;
        int base;
        int idx;
        r = 8'h00;
        base = j * (10 * CPB + 1);
        for (int i = 0; i < 8; i++) begin
            idx = base + 1 + CPB * (1 + i) + CPB / 2;
            if (idx >= smp.size()) return 8'hFF;
            r[i] = smp[idx];
        end
        return r;
    endfunction

    task automatic check_msg(input string nm, input int n,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        chk({nm, "_busylen"}, n, MSG);
        chk({nm, "_loadgap"}, smp.size() > 0 ? 32'(smp[0]) : 32'd9, 1);
        chk({nm, "_startlow"}, smp.size() > 1 ? 32'(smp[1]) : 32'd9, 0);
        chk({nm, "_b0"}, rxbyte(0), e0);
        chk({nm, "_b1"}, rxbyte(1), e1);
        chk({nm, "_b2"}, rxbyte(2), e2);
        chk({nm, "_b3"}, rxbyte(3), e3);
    endtask

    task automatic fire(input logic s, input logic a, input logic b,
                        input logic [3:0] x, input logic [3:0] y);
        @(posedge Clock);
        #1;
        bus.p1Score   = x;
        bus.p2Score   = y;
        bus.evStart   = s;
        bus.evP1Score = a;
        bus.evP2Score = b;
        @(posedge Clock);
        #1;
        bus.evStart   = 1'b0;
        bus.evP1Score = 1'b0;
        bus.evP2Score = 1'b0;
    endtask

    task automatic pulse1();
        @(posedge Clock);
        #1 bus.evP1Score = 1'b1;
        @(posedge Clock);
        #1 bus.evP1Score = 1'b0;
    endtask

    vec_t vt[5];
    int   n;
    int   bad;

    initial begin
        vt[0] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd7, 8'h31, 8'h33, 8'h37, 8'h0D};
        vt[1] = '{1'b1, 1'b0, 1'b0, 4'd10, 4'd15, 8'h53, 8'h41, 8'h46, 8'h0D};
        vt[2] = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 8'h32, 8'h30, 8'h39, 8'h0D};
        vt[3] = '{1'b0, 1'b1, 1'b0, 4'd9, 4'd10, 8'h31, 8'h39, 8'h41, 8'h0D};
        vt[4] = '{1'b1, 1'b0, 1'b0, 4'd15, 4'd0, 8'h53, 8'h46, 8'h30, 8'h0D};

        bus.evStart   = 1'b0;
        bus.evP1Score = 1'b0;
        bus.evP2Score = 1'b0;
        bus.p1Score   = 4'd0;
        bus.p2Score   = 4'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("rst_tx", bus.tx, 1);
            chk("rst_busy", bus.busy, 0);
        end
        @(posedge Clock);
        #2 reset = 1'b1;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("idle_100", bad, 0);

        for (int k = 0; k < 5; k++) begin
            fire(vt[k].s, vt[k].a, vt[k].b, vt[k].p1, vt[k].p2);
            @(negedge Clock);
            chk($sformatf("v%0d_prebusy", k), bus.busy, 0);
            capture(n);
            check_msg($sformatf("v%0d", k), n,
                      vt[k].e0, vt[k].e1, vt[k].e2, vt[k].e3);
            repeat (5) @(posedge Clock);
        end

        // Start and P2 together: start wins, P2 follows after one idle cycle
        fire(1'b1, 1'b0, 1'b1, 4'd1, 4'd2);
        @(negedge Clock);
        capture(n);
        check_msg("sim_a", n, 8'h53, 8'h31, 8'h32, 8'h0D);
        chk("sim_gaplow", bus.busy, 0);
        capture(n);
        check_msg("sim_b", n, 8'h32, 8'h31, 8'h32, 8'h0D);
        repeat (5) @(posedge Clock);

        fire(1'b0, 1'b1, 1'b0, 4'd4, 4'd5);
        @(negedge Clock);
        fork
            capture(n);
            begin
                repeat (10) @(posedge Clock);
                pulse1();
                repeat (30) @(posedge Clock);
                pulse1();
                repeat (30) @(posedge Clock);
                pulse1();
            end
        join
        check_msg("mrg_a", n, 8'h31, 8'h34, 8'h35, 8'h0D);
        capture(n);
        check_msg("mrg_b", n, 8'h31, 8'h34, 8'h35, 8'h0D);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (bus.busy !== 1'b0) bad++;
        end
        chk("mrg_nothird", bad, 0);

        fire(1'b0, 1'b1, 1'b0, 4'd2, 4'd6);
        @(negedge Clock);
        fork
            capture(n);
            begin
                repeat (5) @(posedge Clock);
                #1 bus.p1Score = 4'd5;
            end
        join
        check_msg("snap", n, 8'h31, 8'h32, 8'h36, 8'h0D);
        repeat (5) @(posedge Clock);

        // Reset during the first data bit of '2' (LSB 0), with P2 re-pending
        fire(1'b0, 1'b0, 1'b1, 4'd3, 4'd4);
        @(posedge Clock);
        #1 bus.evP2Score = 1'b1;
        @(posedge Clock);
        #1 bus.evP2Score = 1'b0;
        repeat (4) @(posedge Clock);
        #3;
        chk("ar_pre_tx", bus.tx, 0);
        chk("ar_pre_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        chk("ar_tx", bus.tx, 1);
        chk("ar_busy", bus.busy, 0);
        repeat (3) @(posedge Clock);
        #2 reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("ar_noresume", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
